// File: rtl/bin_to_bcd_display_formatter.sv
// Sequential shift-and-add-3 binary-to-BCD converter with display formatting.
// Results are registered only when a conversion finishes, so the outputs never show partial sums.
module bin_to_bcd_display_formatter #(
  parameter int BIN_WIDTH     = 20,
  parameter int WIDTH_NIBBLES = 6,
  parameter int BLANK_ZEROS   = 1
) (
  input  logic                       clk,
  input  logic                       reset,
  input  logic [BIN_WIDTH-1:0]       bin_in,
  input  logic                       start,
  output logic                       ready,
  output logic                       done,
  output logic                       overflow,
  output logic [WIDTH_NIBBLES*4-1:0] bcd_out,
  output logic [WIDTH_NIBBLES-1:0]   digit_enable_mask
);

  localparam int INT_NIBBLES = (BIN_WIDTH + 2) / 3 + 1;
  localparam int BCD_BITS    = INT_NIBBLES * 4;
  localparam int SCR_BITS    = BCD_BITS + BIN_WIDTH;
  localparam int CNT_W       = $clog2(BIN_WIDTH + 1);
  localparam int EXT_NIBBLES = (INT_NIBBLES > WIDTH_NIBBLES) ? INT_NIBBLES : WIDTH_NIBBLES;

  typedef enum logic [1:0] {IDLE, CONVERT, FINISH} state_t;

  state_t                     state;
  logic [SCR_BITS-1:0]        scratch;
  logic [SCR_BITS-1:0]        adjusted;
  logic [CNT_W-1:0]           cnt;
  logic [EXT_NIBBLES*4-1:0]   ext_digits;
  logic [WIDTH_NIBBLES-1:0]   mask_calc;
  logic [WIDTH_NIBBLES*4-1:0] bcd_calc;
  logic                       ov_calc;

  assign ready = (state == IDLE);

  // Add-3 correction on every BCD nibble before the shift.
  assign adjusted[BIN_WIDTH-1:0] = scratch[BIN_WIDTH-1:0];
  generate
    for (genvar gi = 0; gi < INT_NIBBLES; gi++) begin : g_adj
      assign adjusted[BIN_WIDTH+4*gi +: 4] = (scratch[BIN_WIDTH+4*gi +: 4] >= 4'd5)
                                           ? scratch[BIN_WIDTH+4*gi +: 4] + 4'd3
                                           : scratch[BIN_WIDTH+4*gi +: 4];
    end
  endgenerate

  // Digits widened to cover both the internal and the presented digit counts.
  generate
    if (EXT_NIBBLES > INT_NIBBLES) begin : g_ext_pad
      assign ext_digits = {{((EXT_NIBBLES - INT_NIBBLES) * 4){1'b0}}, scratch[SCR_BITS-1:BIN_WIDTH]};
    end else begin : g_ext_exact
      assign ext_digits = scratch[SCR_BITS-1:BIN_WIDTH];
    end

    if (EXT_NIBBLES > WIDTH_NIBBLES) begin : g_ov
      assign ov_calc = |ext_digits[EXT_NIBBLES*4-1:WIDTH_NIBBLES*4];
    end else begin : g_no_ov
      assign ov_calc = 1'b0;
    end

    for (genvar gi = 0; gi < WIDTH_NIBBLES; gi++) begin : g_mask
      assign mask_calc[gi] = (BLANK_ZEROS == 0) || (gi == 0)
                           || (|ext_digits[WIDTH_NIBBLES*4-1:4*gi]);
    end
  endgenerate

  assign bcd_calc = ov_calc ? {WIDTH_NIBBLES{4'hE}} : ext_digits[WIDTH_NIBBLES*4-1:0];

  always_ff @(posedge clk) begin
    if (reset) begin
      state             <= IDLE;
      done              <= 1'b0;
      overflow          <= 1'b0;
      bcd_out           <= '0;
      digit_enable_mask <= WIDTH_NIBBLES'(1);
      scratch           <= '0;
      cnt               <= '0;
    end else begin
      done <= 1'b0;
      case (state)
        IDLE: begin
          if (start) begin
            scratch <= {{BCD_BITS{1'b0}}, bin_in};
            cnt     <= CNT_W'(BIN_WIDTH);
            state   <= CONVERT;
          end
        end
        CONVERT: begin
          scratch <= adjusted << 1;
          cnt     <= cnt - 1'b1;
          if (cnt == CNT_W'(1)) state <= FINISH;
        end
        FINISH: begin
          overflow          <= ov_calc;
          bcd_out           <= (ov_calc) ? {WIDTH_NIBBLES{4'hE}} : bcd_calc;
          digit_enable_mask <= ov_calc ? {WIDTH_NIBBLES{1'b1}} : mask_calc;
          done              <= 1'b1;
          state             <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_bin_to_bcd_display_formatter.sv
// Randomized bench for bin_to_bcd_display_formatter against a decimal-arithmetic reference.
// Two instances (leading-zero blanking on and off) share stimulus.
module tb_bin_to_bcd_display_formatter;

  logic        clk = 1'b0;
  logic        reset;
  logic [19:0] bin_in;
  logic        start;
  logic        ready0, done0, ov0, ready1, done1, ov1;
  logic [23:0] bcd0, bcd1;
  logic [5:0]  mask0, mask1;

  int tests = 0;
  int fails = 0;

  logic [23:0] prev_bcd;
  logic [5:0]  prev_mask0, prev_mask1;
  logic        prev_ov;

  always #5 clk = ~clk;

  bin_to_bcd_display_formatter #(.BIN_WIDTH(20), .WIDTH_NIBBLES(6), .BLANK_ZEROS(1)) dut_blank (
    .clk(clk), .reset(reset), .bin_in(bin_in), .start(start), .ready(ready0), .done(done0),
    .overflow(ov0), .bcd_out(bcd0), .digit_enable_mask(mask0)
  );

  bin_to_bcd_display_formatter #(.BIN_WIDTH(20), .WIDTH_NIBBLES(6), .BLANK_ZEROS(0)) dut_full (
    .clk(clk), .reset(reset), .bin_in(bin_in), .start(start), .ready(ready1), .done(done1),
    .overflow(ov1), .bcd_out(bcd1), .digit_enable_mask(mask1)
  );

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    tests++;
    if (obs !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Decimal reference: digits by division, mask from the magnitude of the value.
  function automatic void model(input int unsigned v, input bit blank,
                                output logic [23:0] bcd, output logic [5:0] mask,
                                output logic ov);
    int unsigned pw;
    int unsigned d;
    ov = (v > 999999);
    if (ov) begin
      bcd  = 24'hEEEEEE;
      mask = 6'b111111;
    end else begin
      bcd  = '0;
      mask = 6'b000001;
      pw   = 1;
      for (int i = 0; i < 6; i++) begin
        d = (v / pw) % 10;
        bcd[4*i +: 4] = d[3:0];
        if (v >= pw) mask[i] = 1'b1;
        pw = pw * 10;
      end
      if (!blank) mask = 6'b111111;
    end
  endfunction

  // Called at a negedge; returns at the negedge of the done cycle.
  task automatic run_conv(input int unsigned v, input bit keep_start);
    logic [23:0] e_bcd, e_bcd1;
    logic [5:0]  e_mask0, e_mask1;
    logic        e_ov, e_ov1;
    int n, low;
    bit seen;
    model(v, 1'b1, e_bcd, e_mask0, e_ov);
    model(v, 1'b0, e_bcd1, e_mask1, e_ov1);
    check("ready_before_start", ready0, 1'b1);
    bin_in = v[19:0];
    start  = 1'b1;
    @(posedge clk);
    #1;
    bin_in = 20'($urandom);
    if (!keep_start) start = 1'b0;
    n = 0; low = 0; seen = 0;
    while (n < 40 && !seen) begin
      @(negedge clk);
      n++;
      if (!ready0) low++;
      if (done0) seen = 1;
      else begin
        check("hold_bcd", bcd0, prev_bcd);
        check("hold_mask", mask0, prev_mask0);
        check("hold_ov", ov0, prev_ov);
      end
    end
    check("done_seen", seen, 1'b1);
    check("latency", n, 22);
    check("ready_low_cycles", low, 21);
    check("bcd", bcd0, e_bcd);
    check("mask_blank", mask0, e_mask0);
    check("ov", ov0, e_ov);
    check("done_full", done1, 1'b1);
    check("bcd_full", bcd1, e_bcd1);
    check("mask_full", mask1, e_mask1);
    check("ov_full", ov1, e_ov1);
    $display("[TB] conv %0d -> bcd=%06h mask=%06b ov=%0d (full mask=%06b) latency=%0d",
             v, bcd0, mask0, ov0, mask1, n);
    prev_bcd   = e_bcd;
    prev_mask0 = e_mask0;
    prev_mask1 = e_mask1;
    prev_ov    = e_ov;
  endtask

  task automatic check_reset_state(input string tag);
    check({tag, "_ready"}, ready0, 1'b1);
    check({tag, "_done"}, done0, 1'b0);
    check({tag, "_ov"}, ov0, 1'b0);
    check({tag, "_bcd"}, bcd0, 24'h0);
    check({tag, "_mask"}, mask0, 6'b000001);
    check({tag, "_mask_full"}, mask1, 6'b000001);
  endtask

  task automatic expect_no_done(input string tag, input int cycles);
    int cnt_done;
    cnt_done = 0;
    for (int i = 0; i < cycles; i++) begin
      @(negedge clk);
      if (done0 || done1) cnt_done++;
    end
    check(tag, cnt_done, 0);
  endtask

  initial begin
    int unsigned v;
    reset  = 1'b1;
    start  = 1'b0;
    bin_in = '0;
    repeat (3) @(negedge clk);
    check_reset_state("reset");
    reset = 1'b0;
    @(negedge clk);
    prev_bcd = 24'h0; prev_mask0 = 6'b000001; prev_mask1 = 6'b000001; prev_ov = 1'b0;

    run_conv(0, 1'b0);
    run_conv(123456, 1'b0);
    run_conv(42, 1'b1);
    run_conv(77, 1'b0);
    @(negedge clk);
    check("done_one_cycle", done0, 1'b0);
    run_conv(999999, 1'b0);
    run_conv(1000000, 1'b0);
    run_conv(1048575, 1'b0);
    run_conv(7, 1'b0);

    for (int t = 0; t < 20; t++) begin
      case (t % 4)
        0: v = $urandom_range(0, 1048575);
        1: v = $urandom_range(0, 999);
        2: v = $urandom_range(0, 999999);
        default: v = $urandom_range(0, 99);
      endcase
      run_conv(v, 1'b0);
    end

    // Reset in the middle of a conversion.
    bin_in = 20'd654321;
    start  = 1'b1;
    @(posedge clk);
    #1 start = 1'b0;
    repeat (10) @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    check_reset_state("abort");
    $display("[TB] mid-conversion reset -> ready=%0d bcd=%06h mask=%06b", ready0, bcd0, mask0);
    reset = 1'b0;
    expect_no_done("no_done_after_abort", 30);
    prev_bcd = 24'h0; prev_mask0 = 6'b000001; prev_mask1 = 6'b000001; prev_ov = 1'b0;
    run_conv(5, 1'b0);

    // Reset asserted together with start must not begin a conversion.
    @(negedge clk);
    reset  = 1'b1;
    start  = 1'b1;
    bin_in = 20'd31337;
    @(negedge clk);
    start = 1'b0;
    reset = 1'b0;
    check_reset_state("reset_start");
    expect_no_done("no_done_reset_start", 25);
    check("ready_after_reset_start", ready0, 1'b1);
    $display("[TB] reset with start -> ready=%0d bcd=%06h", ready0, bcd0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
